// File: rtl/minv_pkg.sv
// minv_pkg: bank-state encoding, legal bank-count limits and pointer helper
// shared by the minv_bank_sel slice.
package minv_pkg;

    typedef enum logic [1:0] {
        B_FREE  = 2'd0,
        B_ALLOC = 2'd1,
        B_VALID = 2'd2
    } bank_st_t;

    localparam int NBANK_MIN = 2;
    localparam int NBANK_MAX = 8;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1) % n;
    endfunction

endpackage

// File: rtl/minv_rr_pick.sv
// minv_rr_pick: first set bit of i_free at or above i_start, wrapping around;
// o_idx is 0 when nothing is free.
module minv_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_free,
    input  logic [W-1:0] i_start,
    output logic         o_found,
    output logic [W-1:0] o_idx
);

    always_comb begin
        o_found = |i_free;
        o_idx   = '0;
        // Walk downward so the candidate closest to i_start is written last.
        for (int k = N - 1; k >= 0; k--) begin
            if (i_free[(int'(i_start) + k) % N]) o_idx = W'((int'(i_start) + k) % N);
        end
    end

endmodule

// File: rtl/minv_bank_sel.sv
// minv_bank_sel: tracks NBANK result registers as FREE/ALLOC/VALID, grants free
// banks round-robin and reports the newest completed one. Macro MINV_BANK_SEL_ERR_EN adds err_sticky.
module minv_bank_sel
    import minv_pkg::*;
#(
    parameter int NBANK = 4,
    parameter int IDW   = $clog2(NBANK)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           alloc_req,
    output logic           alloc_gnt,
    output logic [IDW-1:0] alloc_id,
    input  logic           done_vld,
    input  logic [IDW-1:0] done_id,
    input  logic           rel_vld,
    input  logic [IDW-1:0] rel_id,
    output logic           cur_vld,
    output logic [IDW-1:0] cur_id,
    output logic [IDW:0]   busy_cnt,
    output logic           full
`ifdef MINV_BANK_SEL_ERR_EN
    ,
    output logic           err_sticky
`endif
);

    localparam int CW = IDW + 1;

    if (NBANK < NBANK_MIN || NBANK > NBANK_MAX) begin : g_bad_nbank
        $error("minv_bank_sel: NBANK out of range");
    end

    bank_st_t       r_state [NBANK];
    bank_st_t       w_state_nxt [NBANK];
    logic [IDW-1:0] r_ptr;
    logic           r_cur_vld;
    logic [IDW-1:0] r_cur_id;
    logic [CW-1:0]  r_busy;
    logic [NBANK-1:0] w_free;
    logic [NBANK-1:0] w_done_hit;
    logic [NBANK-1:0] w_rel_hit;
    logic           w_found;
    logic [IDW-1:0] w_pick;
    logic           w_done_ok;
    logic           w_rel_ok;
    logic           w_same;

    for (genvar i = 0; i < NBANK; i++) begin : g_bank
        assign w_free[i]     = r_state[i] == B_FREE;
        assign w_done_hit[i] = done_vld && done_id == IDW'(i) && r_state[i] == B_ALLOC;
        assign w_rel_hit[i]  = rel_vld && rel_id == IDW'(i) && r_state[i] != B_FREE;
    end

    minv_rr_pick #(
        .N(NBANK),
        .W(IDW)
    ) u_pick (
        .i_free (w_free),
        .i_start(r_ptr),
        .o_found(w_found),
        .o_idx  (w_pick)
    );

    assign w_done_ok = |w_done_hit;
    assign w_rel_ok  = |w_rel_hit;
    assign w_same    = w_done_ok && w_rel_ok && done_id == rel_id;
    // Reset blocks grants so nothing is handed out in a cycle whose state is discarded.
    assign alloc_gnt = alloc_req && w_found && !rst;
    assign alloc_id  = w_pick;
    assign cur_vld   = r_cur_vld;
    assign cur_id    = r_cur_id;
    assign busy_cnt  = r_busy;
    assign full      = r_busy == CW'(NBANK);

    // Release wins over completion; the granted bank is FREE so it never collides with either.
    always_comb begin
        for (int b = 0; b < NBANK; b++) begin
            w_state_nxt[b] = r_state[b];
            if (w_rel_hit[b])
                w_state_nxt[b] = B_FREE;
            else if (w_done_hit[b])
                w_state_nxt[b] = B_VALID;
            else if (alloc_gnt && w_pick == IDW'(b))
                w_state_nxt[b] = B_ALLOC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NBANK; b++) r_state[b] <= B_FREE;
            r_ptr     <= '0;
            r_cur_vld <= 1'b0;
            r_cur_id  <= '0;
            r_busy    <= '0;
        end else begin
            for (int b = 0; b < NBANK; b++) r_state[b] <= w_state_nxt[b];
            if (alloc_gnt) r_ptr <= IDW'(wrap_inc(int'(w_pick), NBANK));
            if (w_same) begin
                r_cur_vld <= 1'b0;
            end else if (w_done_ok) begin
                r_cur_vld <= 1'b1;
                r_cur_id  <= done_id;
            end else if (rel_vld && rel_id == r_cur_id) begin
                r_cur_vld <= 1'b0;
            end
            r_busy <= r_busy + CW'(alloc_gnt) - CW'(w_rel_ok);
        end
    end

`ifdef MINV_BANK_SEL_ERR_EN
    always_ff @(posedge clk) begin
        if (rst)
            err_sticky <= 1'b0;
        else if ((done_vld && !w_done_ok) || (rel_vld && !w_rel_ok))
            err_sticky <= 1'b1;
    end
`endif

endmodule
